// File: rtl/alu_cmd_queue_pkg.sv
// Shared parameters, command record and opcode encodings for the ALU command queue.
// Build option ALU_CMD_COUNT_EN (see alu_cmd_queue.sv) does not affect this package.
package alu_pkg;

    localparam int WIDTH = 8;
    localparam int OPW   = 3;
    localparam int DEPTH = 4;

    localparam logic [OPW-1:0] OP_ADD  = 3'd0;
    localparam logic [OPW-1:0] OP_SUB  = 3'd1;
    localparam logic [OPW-1:0] OP_AND  = 3'd2;
    localparam logic [OPW-1:0] OP_OR   = 3'd3;
    localparam logic [OPW-1:0] OP_XOR  = 3'd4;
    localparam logic [OPW-1:0] OP_SHL  = 3'd5;
    localparam logic [OPW-1:0] OP_SHR  = 3'd6;
    localparam logic [OPW-1:0] OP_NOTA = 3'd7;

    typedef struct packed {
        logic [OPW-1:0]   opcode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_queue_if.sv
// Command, ALU-side and result signals of the ALU command queue, bundled as one interface.
// Slave is the queue's view; master is the view of the surrounding producer/ALU/consumer.
interface alu_cmd_queue_if;
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [OPW-1:0]   alu_opcode;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [OPW-1:0]   out_opcode;

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, alu_y, out_ready,
        output in_ready, alu_opcode, alu_a, alu_b, out_valid, out_y, out_opcode
    );

    modport master (
        output in_valid, in_opcode, in_a, in_b, alu_y, out_ready,
        input  in_ready, alu_opcode, alu_a, alu_b, out_valid, out_y, out_opcode
    );

endinterface

// File: rtl/alu_cmd_queue_fifo.sv
// Synchronous FIFO of alu_cmd_t. Storage is deliberately left uninitialised by reset;
// only pointers and occupancy are cleared. Push while full / pop while empty are ignored.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int N_ENTRIES = DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  alu_cmd_t                       wdata_i,
    input  logic                           pop_i,
    output alu_cmd_t                       rdata_o,
    output logic [$clog2(N_ENTRIES+1)-1:0] count_o,
    output logic                           full_o,
    output logic                           empty_o
);

    localparam int PW = $clog2(N_ENTRIES);
    localparam int CW = $clog2(N_ENTRIES + 1);

    alu_cmd_t        mem_q [N_ENTRIES];
    alu_cmd_t        mem_d [N_ENTRIES];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok_s, pop_ok_s;

    assign full_o    = (count_q == CW'(N_ENTRIES));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign count_o   = count_q;
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign rdata_o   = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; pointers wrap naturally (power-of-2 depth).
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, not reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// Issue stage for an external combinational ALU: command FIFO feeding the ALU, one-entry result register.
// Build option ALU_CMD_COUNT_EN adds a 16-bit wrapping done_cnt of result handshakes.
module alu_cmd_queue
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu_cmd_queue_if.slave    bus
`ifdef ALU_CMD_COUNT_EN
    ,
    output logic [15:0]       done_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    alu_cmd_t         push_cmd_s;
    alu_cmd_t         head_s;
    logic [CW-1:0]    count_s;
    logic             full_s, empty_s;
    logic             push_s, fire_s;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_y_q, out_y_d;
    logic [OPW-1:0]   out_opcode_q, out_opcode_d;

    assign push_cmd_s.opcode = bus.in_opcode;
    assign push_cmd_s.a      = bus.in_a;
    assign push_cmd_s.b      = bus.in_b;

    // in_ready depends on registered occupancy only, never on out_ready.
    assign bus.in_ready = ~full_s;
    assign push_s       = bus.in_valid & ~full_s;
    assign fire_s       = (count_s != {CW{1'b0}}) & (~out_valid_q | bus.out_ready);

    alu_cmd_fifo #(.N_ENTRIES(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .wdata_i (push_cmd_s),
        .pop_i   (fire_s),
        .rdata_o (head_s),
        .count_o (count_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Empty queue presents zeros so stale storage never reaches the ALU.
    assign bus.alu_opcode = empty_s ? {OPW{1'b0}}   : head_s.opcode;
    assign bus.alu_a      = empty_s ? {WIDTH{1'b0}} : head_s.a;
    assign bus.alu_b      = empty_s ? {WIDTH{1'b0}} : head_s.b;

    // Result register: capture on fire, drop valid when drained with nothing behind it.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_y_d      = out_y_q;
        out_opcode_d = out_opcode_q;
        if (fire_s) begin
            out_valid_d  = 1'b1;
            out_y_d      = bus.alu_y;
            out_opcode_d = bus.alu_opcode;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Result register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_y_q      <= {WIDTH{1'b0}};
            out_opcode_q <= {OPW{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            out_y_q      <= out_y_d;
            out_opcode_q <= out_opcode_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_y      = out_y_q;
    assign bus.out_opcode = out_opcode_q;

`ifdef ALU_CMD_COUNT_EN
    logic [15:0] done_cnt_q, done_cnt_d;

    // Completed-result counter, wraps at 16 bits.
    always_comb begin
        if (out_valid_q && bus.out_ready) begin
            done_cnt_d = done_cnt_q + 16'd1;
        end else begin
            done_cnt_d = done_cnt_q;
        end
    end

    // Completed-result counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt_q <= 16'd0;
        end else begin
            done_cnt_q <= done_cnt_d;
        end
    end

    assign done_cnt = done_cnt_q;
`endif

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Bench for alu_cmd_queue: table vectors, hand sequences and randomized traffic checked
// against a queue-based scoreboard fed by a reference ALU model.
module tb_alu_cmd_queue;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_cmd_queue_if bus ();

`ifdef ALU_CMD_COUNT_EN
    logic [15:0] done_cnt;
    alu_cmd_queue dut (.clk(clk), .rst(rst), .bus(bus), .done_cnt(done_cnt));
`else
    alu_cmd_queue dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << 1;
            3'd6:    return a >> 1;
            default: return ~a;
        endcase
    endfunction

    // The "real" ALU the parent would attach.
    always_comb bus.alu_y = alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b);

    typedef struct packed { logic [2:0] op; logic [7:0] y; } res_t;
    typedef struct { logic [2:0] op; logic [7:0] a; logic [7:0] b; logic [7:0] y; } vec_t;

    res_t exp_q[$];
    vec_t vt[9];
    int checks = 0, failures = 0;
    int cyc = 0, acc_cnt = 0, del_cnt = 0, hs_cnt = 0, first_del = -1, last_del = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // One clock: observe handshakes at the falling edge, then step past the rising edge.
    task automatic cycle();
        res_t e;
        @(negedge clk);
        if (!rst) chk("in_ready_vs_occupancy", {31'd0, bus.in_ready}, {31'd0, exp_q.size() != DEPTH + 1});
        if (bus.out_valid && bus.out_ready) begin
            del_cnt++;
            hs_cnt++;
            if (first_del < 0) first_del = cyc;
            last_del = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got op=%0h y=%0h required none", bus.out_opcode, bus.out_y);
            end else begin
                e = exp_q.pop_front();
                chk("result_opcode", {29'd0, bus.out_opcode}, {29'd0, e.op});
                chk("result_y", {24'd0, bus.out_y}, {24'd0, e.y});
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            acc_cnt++;
            exp_q.push_back(res_t'{op: bus.in_opcode, y: alu_f(bus.in_opcode, bus.in_a, bus.in_b)});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_complete", exp_q.size(), 32'd0);
    endtask

    task automatic rand_cmd();
        bus.in_opcode = 3'($urandom_range(0, 7));
        bus.in_a      = 8'($urandom % 256);
        bus.in_b      = 8'($urandom % 256);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #3;
        exp_q.delete();
        hs_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, d0, n;
        vt[0] = '{3'd0, 8'h12, 8'h34, 8'h46};
        vt[1] = '{3'd1, 8'h50, 8'h60, 8'hF0};
        vt[2] = '{3'd2, 8'hF0, 8'h3C, 8'h30};
        vt[3] = '{3'd3, 8'hF0, 8'h0F, 8'hFF};
        vt[4] = '{3'd4, 8'hAA, 8'hFF, 8'h55};
        vt[5] = '{3'd5, 8'h81, 8'h00, 8'h02};
        vt[6] = '{3'd6, 8'h81, 8'h00, 8'h40};
        vt[7] = '{3'd7, 8'h0F, 8'h00, 8'hF0};
        vt[8] = '{3'd0, 8'hFF, 8'h01, 8'h00};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_opcode = 3'd0; bus.in_a = 8'd0; bus.in_b = 8'd0;
        rst = 1'b1;
        #12;
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_out_y", {24'd0, bus.out_y}, 32'd0);
        chk("reset_out_opcode", {29'd0, bus.out_opcode}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("reset_alu_a", {24'd0, bus.alu_a}, 32'd0);

        // Single commands from the table: latency and result value.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.in_valid = 1'b1;
            bus.in_opcode = vt[i].op; bus.in_a = vt[i].a; bus.in_b = vt[i].b;
            cycle();
            bus.in_valid = 1'b0;
            chk("latency_not_early", {31'd0, bus.out_valid}, 32'd0);
            cycle();
            chk("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("vec_out_y", {24'd0, bus.out_y}, {24'd0, vt[i].y});
            chk("vec_out_opcode", {29'd0, bus.out_opcode}, {29'd0, vt[i].op});
            cycle();
            chk("drained_out_valid", {31'd0, bus.out_valid}, 32'd0);
        end

        // Reset mid-stream with commands queued.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            rand_cmd();
            cycle();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        exp_q.delete();
        hs_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_alu_opcode", {29'd0, bus.alu_opcode}, 32'd0);
        chk("postrst_alu_a", {24'd0, bus.alu_a}, 32'd0);
        chk("postrst_alu_b", {24'd0, bus.alu_b}, 32'd0);
        chk("postrst_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Fill under backpressure: one in the result register plus DEPTH queued.
        bus.out_ready = 1'b0;
        a0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            rand_cmd();
            cycle();
        end
        bus.in_valid = 1'b0;
        chk("fill_accepted", acc_cnt - a0, 32'd5);
        chk("fill_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("fill_out_valid", {31'd0, bus.out_valid}, 32'd1);
        cycle();
        chk("stall_out_y_stable", {24'd0, bus.out_y}, {24'd0, exp_q[0].y});
        chk("stall_out_opcode_stable", {29'd0, bus.out_opcode}, {29'd0, exp_q[0].op});
        del_cnt = 0;
        drain(30);
        chk("fill_delivered", del_cnt, 32'd5);

        // Streaming: back-to-back with pointer wrap.
        del_cnt = 0; first_del = -1; a0 = acc_cnt;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            rand_cmd();
            bus.in_opcode = 3'(i % 8);
            cycle();
        end
        bus.in_valid = 1'b0;
        chk("stream_accepted", acc_cnt - a0, 32'd16);
        drain(30);
        chk("stream_delivered", del_cnt, 32'd16);
        chk("stream_consecutive", last_del - first_del, 32'd15);

        // Random traffic with random backpressure.
        a0 = acc_cnt; d0 = del_cnt; n = 0;
        while (acc_cnt - a0 < 256 && n < 5000) begin
            bus.in_valid  = ($urandom % 10) < 7;
            bus.out_ready = ($urandom % 10) < 6;
            rand_cmd();
            cycle();
            n++;
        end
        bus.in_valid = 1'b0;
        chk("random_accepted", acc_cnt - a0, 32'd256);
        drain(50);
        chk("random_delivered", del_cnt - d0, 32'd256);

`ifdef ALU_CMD_COUNT_EN
        do_reset();
        bus.out_ready = 1'b1;
        a0 = acc_cnt; n = 0;
        while (acc_cnt - a0 < 70000 && n < 71000) begin
            bus.in_valid = (acc_cnt - a0) < 69999;
            rand_cmd();
            cycle();
            n++;
            if (acc_cnt - a0 >= 70000) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        drain(20);
        chk("count_handshakes", hs_cnt, 32'd70000);
        chk("done_cnt_wrap", {16'd0, done_cnt}, 32'd4464);
`endif

        chk("final_scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
